// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor: decodes which LED pattern mode is running and reports lock/mode-change/glitch
module led_pattern_monitor #(
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 3
) (
   input  logic       div_clk_out,
   input  logic       rst,
   input  logic [3:0] led_in,
   output logic [1:0] det_mode,
   output logic       locked,
   output logic       mode_change,
   output logic       glitch_err
);

   typedef enum logic [1:0] {IDLE, HUNT, CONFIRM, LOCKED} state_t;

   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_nxt;
   logic [3:0]       prev;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [1:0]       cand, cand_nxt, det_nxt;
   logic             locked_nxt, mc_nxt, ge_nxt, first_lock, first_nxt;
   logic [3:0]       rot_r, rot_l;
   logic             c00, c01, c10, c11, is_amb, is_valid;
   logic [1:0]       cls;
   logic             lock_entry, lock_drop;

   assign cnt_inc = cnt + CNT_ONE;

   // classify the (prev, led_in) pair into a pattern class, ambiguous or mismatch
   always_comb begin
      rot_r    = {prev[0], prev[3:1]};
      rot_l    = {prev[2:0], prev[3]};
      c00      = (prev == 4'b0000) && (led_in == 4'b0000);
      c11      = (prev == 4'b0001) && (led_in == 4'b0001);
      c01      = (led_in == rot_r) && (led_in != rot_l) && (led_in != prev);
      c10      = (led_in == rot_l) && (led_in != rot_r) && (led_in != prev);
      is_amb   = (led_in == rot_r) && (led_in == rot_l) && (led_in != prev);
      is_valid = c00 | c01 | c10 | c11;
      cls      = c11 ? 2'b11 : c10 ? 2'b10 : c01 ? 2'b01 : 2'b00;
   end

   // state register plus all registered outputs; prev follows the bus every edge
   always_ff @(posedge div_clk_out or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         prev        <= 4'b0000;
         cnt         <= '0;
         cand        <= 2'b00;
         det_mode    <= 2'b00;
         locked      <= 1'b0;
         mode_change <= 1'b0;
         glitch_err  <= 1'b0;
         first_lock  <= 1'b1;
      end else begin
         state       <= state_nxt;
         prev        <= led_in;
         cnt         <= cnt_nxt;
         cand        <= cand_nxt;
         det_mode    <= det_nxt;
         locked      <= locked_nxt;
         mode_change <= mc_nxt;
         glitch_err  <= ge_nxt;
         first_lock  <= first_nxt;
      end
   end

   // next-state: hunt for a valid class, confirm it LOCK_CNT times, then watch for breaks
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      case (state)
         IDLE: state_nxt = HUNT;
         HUNT: begin
            if (is_valid) begin
               cand_nxt  = cls;
               cnt_nxt   = CNT_ONE;
               state_nxt = CONFIRM;
            end
         end
         CONFIRM: begin
            if (is_valid && cls == cand) begin
               cnt_nxt   = cnt_inc;
               state_nxt = (cnt_inc == LOCK_MAX) ? LOCKED : CONFIRM;
            end else if (is_amb && (cand[1] ^ cand[0])) begin
               cnt_nxt = cnt;
            end else if (is_valid) begin
               cand_nxt = cls;
               cnt_nxt  = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
               state_nxt = HUNT;
            end
         end
         LOCKED: begin
            if ((is_valid && cls == det_mode) || (is_amb && (det_mode[1] ^ det_mode[0]))) begin
               state_nxt = LOCKED;
            end else if (is_valid) begin
               cand_nxt  = cls;
               cnt_nxt   = CNT_ONE;
               state_nxt = CONFIRM;
            end else begin
               cnt_nxt   = '0;
               state_nxt = HUNT;
            end
         end
      endcase
   end

   // outputs: lock entry/drop edges drive det_mode, locked and the one-cycle pulses
   always_comb begin
      lock_entry = (state == CONFIRM) && (state_nxt == LOCKED);
      lock_drop  = (state == LOCKED) && (state_nxt != LOCKED);
      det_nxt    = lock_entry ? cand : det_mode;
      locked_nxt = lock_entry ? 1'b1 : lock_drop ? 1'b0 : locked;
      mc_nxt     = lock_entry && (first_lock || cand != det_mode);
      ge_nxt     = lock_drop;
      first_nxt  = lock_entry ? 1'b0 : first_lock;
   end

endmodule
